serial_subtractor_4bit: RTL and testbench
=========================================

# serial_subtractor_4bit

Bit-serial, multi-cycle subtractor that computes D = A − B − Bin one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow. It is the subtracting counterpart to the team's ripple-carry adder. It serves datapaths that trade latency for area, using a start/done handshake toward the controlling FSM. The width is parameterised; the 4-bit configuration is the reference build.

## Interface
- N, default 4: operand and result width in bits (N ≥ 2).
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  N  minuend; captured on the accepted start edge.
- b  input  N  subtrahend; captured on the accepted start edge.
- bin  input  1  borrow-in; captured on the accepted start edge.
- busy  output  1  high while state ≠ IDLE.
- done  output  1  single-cycle completion strobe.
- d  output  N  difference (a − b − bin) mod 2^N; registered.
- bout  output  1  borrow-out: 1 iff unsigned a < b + bin.
- ovf  output  1  signed (two's-complement) overflow of the subtraction.

## Operation
- FSM states: IDLE, SHIFT, DONE.
  - IDLE → SHIFT on start = 1.
  - SHIFT → DONE after N bit-steps.
  - DONE → IDLE unconditionally after one cycle.
- On accepted start:
  - Latch a, b and bin into internal operand registers.
  - Load the borrow register with bin.
  - Clear the bit counter (width ceil(log2 N) + 1).
  - Clear the internal difference shift register.
- Each SHIFT cycle, with bit i = counter and br = borrow register:
  - diff_i = a_i ^ b_i ^ br.
  - br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
  - Write diff_i into bit i of the internal shift register, update br, and increment the counter.
- On the edge that processes bit N−1:
  - Transfer the full difference to d.
  - Set bout = br_next.
  - Set ovf = (a[N−1] ≠ b[N−1]) & (diff[N−1] ≠ a[N−1]), using the latched operands.
  - Enter DONE.
- d, bout and ovf are updated only at completion. They hold their values through IDLE until the next completion.
- start is ignored in SHIFT and DONE. No queuing; the request is lost.
- Changes to a, b and bin after the start edge have no effect on the operation in flight.
- Arithmetic wraps modulo 2^N. The borrow out of the MSB appears only on bout, never in d.

## Timing
- Reset (rst = 1 at an edge) overrides everything, including mid-operation:
  - State → IDLE.
  - busy = 0, done = 0, d = 0, bout = 0, ovf = 0.
  - Internal operands, borrow and counter cleared.
  - An operation in flight is discarded, with no done.
- If rst and start are high on the same edge, reset wins.
- Start accepted at edge E0. SHIFT covers edges E1..EN, and results plus the DONE state are registered at EN.
- busy rises after E0 and falls after EN+1 (N+1 cycles high).
- done is high for exactly one cycle, between EN and EN+1.
- Latency, start edge to done visible: N cycles.
- Throughput: one operation per N+2 cycles. A start held high continuously is re-accepted on the first IDLE edge (EN+1 is in DONE, so the next accept is EN+2).
- No combinational path from inputs to outputs.

## Test plan
- Reset and back-to-back operation:
  - Assert rst for 2 cycles → busy = 0, done = 0, d = 0000, bout = 0, ovf = 0.
  - Then run a = 1000, b = 0011, bin = 0 → after 4 cycles d = 0101, bout = 0, ovf = 1, done pulses one cycle.
  - Then a = 1101, b = 1010, bin = 1 → d = 0010, bout = 0, ovf = 0.
- Borrow-out cases:
  - a = 0001, b = 0011, bin = 0 → d = 1110, bout = 1, ovf = 0.
  - a = 1110, b = 1001, bin = 0 → d = 0101, bout = 0, ovf = 0.
- Wrap-around: a = 0000, b = 1111, bin = 1 → d = 0000, bout = 1, ovf = 0.
- Start during busy:
  - Start a = 0111, b = 0001.
  - Pulse start with a = 1111, b = 1111 at E2 → ignored; result d = 0110, bout = 0, ovf = 0, exactly one done.
  - Operand changes after E0 do not alter the result.
- Reset mid-op:
  - Start a = 1010, b = 0101, then assert rst at E2 → next cycle all outputs 0, state IDLE, no done ever.
  - A fresh start afterwards with a = 1010, b = 0101, bin = 0 → d = 0101, bout = 0, ovf = 1.
- Held start and latency:
  - Keep start = 1 continuously → accepts spaced exactly 6 cycles apart (N = 4).
  - done occurs 4 cycles after each accept; busy is high 5 cycles per operation.

Source files
------------

// File: rtl/serial_subtractor_4bit.sv
// serial_subtractor_4bit
// Bit-serial subtractor: D = A - B - Bin, one bit per clock, LSB first,
// through a single full-subtractor cell and a registered borrow. A start/done
// handshake frames each operation; results are registered and held until the
// next completion.

module serial_subtractor_4bit #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] d,
  output logic         bout,
  output logic         ovf
);

  // Counter holds 0..N, so it needs one bit more than the bit index.
  localparam int CW = $clog2(N) + 1;
  localparam int IW = CW - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, a_d;        // latched minuend
  logic [N-1:0]   b_q, b_d;        // latched subtrahend
  logic           br_q, br_d;      // running borrow
  logic [CW-1:0]  cnt_q, cnt_d;    // index of the bit processed next
  logic [N-1:0]   diff_q, diff_d;  // difference assembled bit by bit
  logic [N-1:0]   dout_q, dout_d;  // published difference
  logic           bout_q, bout_d;  // published borrow-out
  logic           ovf_q, ovf_d;    // published signed overflow

  // Full-subtractor cell signals for the current bit.
  logic [IW-1:0]  idx;
  logic           a_bit;
  logic           b_bit;
  logic           diff_bit;
  logic           br_next;
  logic           last_bit;
  logic [N-1:0]   diff_ins;

  // Single full-subtractor cell operating on bit cnt_q of the latched operands.
  always_comb begin
    idx      = cnt_q[IW-1:0];
    a_bit    = a_q[idx];
    b_bit    = b_q[idx];
    diff_bit = a_bit ^ b_bit ^ br_q;
    br_next  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
    last_bit = (cnt_q == CW'(N - 1));
    diff_ins      = diff_q;
    diff_ins[idx] = diff_bit;
  end

  // Next-state and datapath control for the IDLE/SHIFT/DONE sequence.
  always_comb begin
    // NOTE: every variable gets its hold value first, so no path leaves one
    // unassigned and no latch is inferred.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    dout_d  = dout_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          cnt_d   = '0;
          diff_d  = '0;
        end
      end

      SHIFT: begin
        diff_d = diff_ins;
        br_d   = br_next;
        cnt_d  = cnt_q + CW'(1);
        if (last_bit) begin
          // Publish results on the edge that processes the MSB.
          state_d = DONE;
          dout_d  = diff_ins;
          bout_d  = br_next;
          ovf_d   = (a_q[N-1] ^ b_q[N-1]) & (diff_bit ^ a_q[N-1]);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset that aborts any
  // operation in flight.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      dout_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      dout_q  <= dout_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  // All outputs come straight from registers.
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign d    = dout_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor_4bit.sv
// Self-checking bench for serial_subtractor_4bit (N = 4): table vectors,
// randomised vectors against an integer model, and hand-written sequences
// for start-while-busy, reset mid-operation and held start.

module tb_serial_subtractor_4bit;

  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [N-1:0] d;
  logic         bout;
  logic         ovf;

  serial_subtractor_4bit #(.N(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .d    (d),
    .bout (bout),
    .ovf  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] d;
    logic         bout;
    logic         ovf;
  } exp_t;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bin;
    logic [N-1:0] d;
    logic         bout;
    logic         ovf;
  } vec_t;

  int   compared   = 0;
  int   mismatched = 0;
  int   done_count = 0;
  exp_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model written with plain integer arithmetic.
  function automatic exp_t model(input logic [N-1:0] av, input logic [N-1:0] bv,
                                 input logic binv);
    exp_t r;
    int   ua;
    int   ub;
    int   sa;
    int   sb;
    int   t;
    int   sres;
    ua   = int'(av);
    ub   = int'(bv);
    sa   = ua - (av[N-1] ? (1 << N) : 0);
    sb   = ub - (bv[N-1] ? (1 << N) : 0);
    t    = ua - ub - int'(binv);
    sres = sa - sb - int'(binv);
    r.d    = t[N-1:0];
    r.bout = (ua < ub + int'(binv));
    r.ovf  = (sres < -(1 << (N - 1))) || (sres > (1 << (N - 1)) - 1);
    return r;
  endfunction

  // Scoreboard: every done pops one expected result.
  always @(negedge clk) begin : sb_monitor
    exp_t e;
    if (done === 1'b1) begin
      done_count++;
      if (sb_q.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("sb_d",    32'(d),    32'(e.d));
        check("sb_bout", 32'(bout), 32'(e.bout));
        check("sb_ovf",  32'(ovf),  32'(e.ovf));
      end
    end
  end

  // One complete operation from IDLE; checks latency and the return to IDLE.
  task automatic run_op(input logic [N-1:0] av, input logic [N-1:0] bv,
                        input logic binv, input exp_t e, input string tag);
    int lat;
    bit got;
    @(negedge clk);
    a     = av;
    b     = bv;
    bin   = binv;
    start = 1'b1;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = N'($urandom);
    b     = N'($urandom);
    bin   = 1'($urandom);
    check({tag, "_busy_rise"}, 32'(busy), 32'd1);
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 3 * N && !got; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) got = 1'b1;
    end
    check({tag, "_latency"}, got ? 32'(lat) : 32'hffff_ffff, 32'(N));
    @(posedge clk);
    #1;
    check({tag, "_idle_after"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin : main
    vec_t vecs[6];
    exp_t e;
    int   dc0;
    bit   got;
    int   acc[$];
    int   dn[$];
    int   busy_hi;
    bit   prev_busy;

    vecs[0] = '{a: 4'b1000, b: 4'b0011, bin: 1'b0, d: 4'b0101, bout: 1'b0, ovf: 1'b1};
    vecs[1] = '{a: 4'b1101, b: 4'b1010, bin: 1'b1, d: 4'b0010, bout: 1'b0, ovf: 1'b0};
    vecs[2] = '{a: 4'b0001, b: 4'b0011, bin: 1'b0, d: 4'b1110, bout: 1'b1, ovf: 1'b0};
    vecs[3] = '{a: 4'b1110, b: 4'b1001, bin: 1'b0, d: 4'b0101, bout: 1'b0, ovf: 1'b0};
    vecs[4] = '{a: 4'b0000, b: 4'b1111, bin: 1'b1, d: 4'b0000, bout: 1'b1, ovf: 1'b0};
    vecs[5] = '{a: 4'b1000, b: 4'b0000, bin: 1'b1, d: 4'b0111, bout: 1'b0, ovf: 1'b1};

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;

    // Reset for two cycles.
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_d",    32'(d),    32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    check("rst_ovf",  32'(ovf),  32'd0);
    rst = 1'b0;

    // Table vectors, back to back.
    for (int i = 0; i < 6; i++) begin
      e = '{d: vecs[i].d, bout: vecs[i].bout, ovf: vecs[i].ovf};
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, e, $sformatf("vec%0d", i));
    end

    // Random vectors against the model.
    for (int i = 0; i < 8; i++) begin
      logic [N-1:0] ra;
      logic [N-1:0] rb;
      logic         rbin;
      ra   = N'($urandom);
      rb   = N'($urandom);
      rbin = 1'($urandom);
      run_op(ra, rb, rbin, model(ra, rb, rbin), $sformatf("rnd%0d", i));
    end

    // Start pulsed while busy is ignored; operand changes have no effect.
    @(negedge clk);
    a     = 4'b0111;
    b     = 4'b0001;
    bin   = 1'b0;
    start = 1'b1;
    sb_q.push_back('{d: 4'b0110, bout: 1'b0, ovf: 1'b0});
    dc0 = done_count;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 4'b1111;
    b     = 4'b1111;
    bin   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_ign_busy", 32'(busy), 32'd1);
    got = 1'b0;
    for (int i = 0; i < 3 * N && !got; i++) begin
      @(posedge clk);
      #1;
      if (done) got = 1'b1;
    end
    check("busy_ign_done_seen", 32'(got), 32'd1);
    repeat (2 * N) @(posedge clk);
    #1;
    check("busy_ign_one_done", 32'(done_count - dc0), 32'd1);
    check("busy_ign_idle", 32'(busy), 32'd0);

    // Reset in the middle of an operation.
    @(negedge clk);
    a     = 4'b1010;
    b     = 4'b0101;
    bin   = 1'b0;
    start = 1'b1;
    dc0   = done_count;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_d",    32'(d),    32'd0);
    check("midrst_bout", 32'(bout), 32'd0);
    check("midrst_ovf",  32'(ovf),  32'd0);
    repeat (3 * N) @(posedge clk);
    #1;
    check("midrst_no_done", 32'(done_count - dc0), 32'd0);
    run_op(4'b1010, 4'b0101, 1'b0, '{d: 4'b0101, bout: 1'b0, ovf: 1'b1}, "after_rst");

    // Start held high: accepts every N+2 cycles.
    @(negedge clk);
    a     = 4'b1000;
    b     = 4'b0011;
    bin   = 1'b0;
    start = 1'b1;
    for (int k = 0; k < 3; k++) sb_q.push_back('{d: 4'b0101, bout: 1'b0, ovf: 1'b1});
    busy_hi   = 0;
    prev_busy = busy;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (busy && !prev_busy) begin
        acc.push_back(c);
        if (acc.size() == 3) start = 1'b0;
      end
      if (busy) busy_hi++;
      if (done) dn.push_back(c);
      prev_busy = busy;
      if (dn.size() == 3 && !busy) break;
    end
    start = 1'b0;
    check("held_accepts", 32'(acc.size()), 32'd3);
    check("held_dones",   32'(dn.size()),  32'd3);
    if (acc.size() == 3 && dn.size() == 3) begin
      check("held_spacing0", 32'(acc[1] - acc[0]), 32'(N + 2));
      check("held_spacing1", 32'(acc[2] - acc[1]), 32'(N + 2));
      for (int k = 0; k < 3; k++)
        check($sformatf("held_latency%0d", k), 32'(dn[k] - acc[k]), 32'(N));
      check("held_busy_cycles", 32'(busy_hi), 32'(3 * (N + 1)));
    end

    repeat (4) @(posedge clk);
    #1;
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
